// File: rtl/twos_comp_pkg.sv
// Shared definitions for the serial two's-complement receive path.
//   W_DEFAULT : default frame/word width in bits.
//   state_t   : receive state machine encoding (IDLE waits for sof, RECV collects bits).
package twos_comp_pkg;

    localparam int W_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

// File: rtl/twos_comp_deserializer_if.sv
// Bus bundle between the serial link, the deserializer and the parallel consumer.
// Signals:
//   sin, sin_valid, sof     : serial bit, its qualifier and start-of-frame marker
//   dout, dout_raw          : recovered word and word as received
//   dout_valid, dout_ready  : parallel output handshake
//   overrun, frame_err      : sticky drop flag and mid-frame abort pulse
// Modports:
//   slave  : the deserializer side
//   master : the stimulus / consumer side
interface twos_comp_deserializer_if
    import twos_comp_pkg::*;
#(
    parameter int W = W_DEFAULT
);

    logic         sin;
    logic         sin_valid;
    logic         sof;
    logic [W-1:0] dout;
    logic [W-1:0] dout_raw;
    logic         dout_valid;
    logic         dout_ready;
    logic         overrun;
    logic         frame_err;

    modport slave (
        input  sin,
        input  sin_valid,
        input  sof,
        input  dout_ready,
        output dout,
        output dout_raw,
        output dout_valid,
        output overrun,
        output frame_err
    );

    modport master (
        output sin,
        output sin_valid,
        output sof,
        output dout_ready,
        input  dout,
        input  dout_raw,
        input  dout_valid,
        input  overrun,
        input  frame_err
    );

endinterface

// File: rtl/twos_comp_deserializer_negate_cell.sv
// Bit-serial two's-complement negation cell (LSB first).
// Bits up to and including the first 1 pass unchanged; every later bit is inverted.
// Ports:
//   clk     : clock
//   srst    : synchronous active-high reset
//   clear   : first bit of a new frame (already qualified by enable)
//   enable  : a bit is accepted this cycle
//   bit_in  : incoming serial bit
//   bit_out : negated bit for bit_in (combinational)
module serial_negate_cell (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    input  logic bit_in,
    output logic bit_out
);

    logic seen_one_reg;

    // A clearing bit is the first bit of a frame, so it never sees an
    // earlier 1 even if the flop still holds one from the aborted frame.
    assign bit_out = (seen_one_reg & ~clear) ? ~bit_in : bit_in;

    always_ff @(posedge clk) begin
        if (srst) begin
            seen_one_reg <= 1'b0;
        end else if (enable) begin
            if (clear) begin
                seen_one_reg <= bit_in;
            end else begin
                seen_one_reg <= seen_one_reg | bit_in;
            end
        end
    end

endmodule

// File: rtl/twos_comp_deserializer.sv
// Receive-end deserializer for LSB-first serial two's-complement frames.
// Collects W-bit frames, undoes the sender's negation bit-serially and
// presents both the raw and the recovered word with a valid/ready handshake.
// Ports:
//   t_clk : clock, all state updates on the rising edge
//   r     : synchronous active-high reset
//   bus   : slave side of twos_comp_deserializer_if (serial in, parallel out, flags)
module twos_comp_deserializer
    import twos_comp_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic                      t_clk,
    input  logic                      r,
    twos_comp_deserializer_if.slave   bus
);

    localparam int            CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state_reg;
    logic [CW-1:0] count_reg;
    logic [W-1:0]  raw_reg;
    logic [W-1:0]  neg_reg;
    logic [W-1:0]  raw_next;
    logic [W-1:0]  neg_next;
    logic [W-1:0]  dout_reg;
    logic [W-1:0]  dout_raw_reg;
    logic          dout_valid_reg;
    logic          overrun_reg;
    logic          frame_err_reg;

    logic          accept;
    logic          start;
    logic          rec_bit;
    logic [CW-1:0] idx;
    logic          frame_done;

    assign accept = bus.sin_valid;
    assign start  = bus.sin_valid & bus.sof;

    // sof always writes position 0, even when it aborts a frame in progress.
    assign idx = start ? '0 : count_reg;

    // With W >= 2 a starting bit can never also be the last bit.
    assign frame_done = accept & ~start & (state_reg == RECV) & (count_reg == LAST);

    serial_negate_cell u_negate (
        .clk     (t_clk),
        .srst    (r),
        .clear   (start),
        .enable  (accept),
        .bit_in  (bus.sin),
        .bit_out (rec_bit)
    );

    // Next-value shift images: the current bit lands at idx; a new frame
    // clears the rest so no bits of an aborted frame linger.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bits
            assign raw_next[gi] = (idx == CW'(gi)) ? bus.sin
                                : (start ? 1'b0 : raw_reg[gi]);
            assign neg_next[gi] = (idx == CW'(gi)) ? rec_bit
                                : (start ? 1'b0 : neg_reg[gi]);
        end
    endgenerate

    always_ff @(posedge t_clk) begin
        if (r) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            raw_reg        <= '0;
            neg_reg        <= '0;
            dout_reg       <= '0;
            dout_raw_reg   <= '0;
            dout_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;

            // Receive side
            if (start) begin
                frame_err_reg <= (state_reg == RECV);
                state_reg     <= RECV;
                count_reg     <= CW'(1);
                raw_reg       <= raw_next;
                neg_reg       <= neg_next;
            end else if (accept && state_reg == RECV) begin
                raw_reg <= raw_next;
                neg_reg <= neg_next;
                if (count_reg == LAST) begin
                    state_reg <= IDLE;
                    count_reg <= '0;
                end else begin
                    count_reg <= count_reg + CW'(1);
                end
            end

            // Output side: a completed word loads only if the holding
            // register is free or being emptied in this same cycle.
            if (frame_done) begin
                if (!dout_valid_reg || bus.dout_ready) begin
                    dout_reg       <= neg_next;
                    dout_raw_reg   <= raw_next;
                    dout_valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (dout_valid_reg && bus.dout_ready) begin
                dout_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.dout       = dout_reg;
    assign bus.dout_raw   = dout_raw_reg;
    assign bus.dout_valid = dout_valid_reg;
    assign bus.overrun    = overrun_reg;
    assign bus.frame_err  = frame_err_reg;

endmodule

// File: doc/twos_comp_deserializer.md
Name: twos_comp_deserializer

Overview:
- Receive-end block for the LSB-first serial two's-complement stream produced by the team's serial negator.
- Captures W-bit frames and undoes the negation bit-serially, so `dout` = -(received word) mod 2^W.
- Presents the raw word and the recovered word on a parallel output with a valid/ready handshake.
- Sits between the serial link and the parallel datapath consumer.

Parameters:
- W, 8, frame/word width in bits; legal range W >= 2.

Ports:
- t_clk  input  1  clock; all state updates on rising edge.
- r  input  1  reset, synchronous, active-high.
- sin  input  1  serial data bit, LSB of frame first.
- sin_valid  input  1  `sin` is sampled this cycle.
- sof  input  1  start of frame; qualified by `sin_valid`; marks the bit as bit 0.
- dout  output  W  recovered word (serial two's complement of the received bits).
- dout_raw  output  W  received bits as sent.
- dout_valid  output  1  output word available.
- dout_ready  input  1  consumer accepts word when `dout_valid` & `dout_ready`.
- overrun  output  1  sticky: a completed frame was dropped.
- frame_err  output  1  one-cycle pulse: frame aborted by `sof` mid-frame.

Behaviour:
- Reset (`r`=1 at rising edge):
  - state=IDLE, bit count=0, seen_one=0, shift registers=0.
  - `dout`=0, `dout_raw`=0, `dout_valid`=0, `overrun`=0, `frame_err`=0.
  - Reset mid-frame discards the partial frame. Reset with `dout_valid`=1 discards the held word.
- Accepted bit = `sin_valid`=1 at a rising edge. No `sin_valid` means no state change on the receive side.
- State IDLE:
  - An accepted bit with `sof`=1 becomes bit 0; go to RECV, count=1.
  - Accepted bits with `sof`=0 are ignored.
- State RECV:
  - Each accepted bit is stored at index = count; count increments.
  - Accepted bit with `sof`=1 aborts the partial frame: `frame_err`=1 for the next cycle. That bit restarts as bit 0 (count=1, seen_one recomputed from it).
- Negation rule, per accepted bit b:
  - Recovered bit = seen_one ? ~b : b.
  - Then seen_one <= seen_one | b.
  - seen_one is cleared by `sof`.
  - Raw bit b is stored unchanged.
- Completion:
  - The edge accepting bit W-1 loads `dout`/`dout_raw` from the shifted-in values including that bit.
  - At the same edge: `dout_valid`<=1, state<=IDLE, count<=0.
  - Latency: word visible one cycle after its last bit is sampled.
- Handshake:
  - `dout_valid` and `dout`/`dout_raw` are held stable until a cycle with `dout_ready`=1; `dout_valid` clears at that edge.
  - Completion in the same cycle as the handshake: new word loads, `dout_valid` stays 1.
  - Completion while `dout_valid`=1 and `dout_ready`=0: new word dropped, old word kept, `overrun`<=1 (sticky until reset).
- Width/arithmetic:
  - Bit counter is $clog2(W) bits.
  - Result is modulo 2^W; -(2^(W-1)) maps to itself; 0 maps to 0.
- Gaps (`sin_valid`=0) inside a frame are allowed for any duration; no timeout.

Decomposition:
- Package twos_comp_pkg:
  - default width constant W_DEFAULT=8.
  - state enum {IDLE, RECV}.
- Sub-module serial_negate_cell:
  - Ports: clock, reset, clear (=`sof`&`sin_valid`), enable (=`sin_valid`), bit in, recovered bit out (combinational from seen_one and bit in).
  - Holds the seen_one flop.
  - Top level holds counter, shift registers, output register, handshake and flags.

Test Plan:
- W=8, `dout_ready`=1, frame LSB-first 1,1,0,1,1,1,1,1 (0xFB) with `sof` on the first bit, `sin_valid` continuous -> one cycle after bit 7: `dout_raw`=0xFB, `dout`=0x05, `dout_valid`=1 for one cycle.
- Frames 0x00 and 0x80 back-to-back, no gaps -> `dout`=0x00/`dout_raw`=0x00, then `dout`=0x80/`dout_raw`=0x80; no `frame_err`/`overrun`.
- Frame 0xFB with `sin_valid` low for 3 cycles after bits 2 and 5 -> same result as scenario 1; `dout_valid` rises exactly one cycle after bit 7 is sampled.
- Start frame, `sof` again at bit 4 with new frame 0x01 (bits 1,0,0,0,0,0,0,0) -> `frame_err` one-cycle pulse; then `dout_raw`=0x01, `dout`=0xFF.
- `dout_ready`=0; send 0xFB then 0x02 -> `dout` stays 0x05, `overrun`=1 after the second frame completes. Raise `dout_ready` -> 0x05 consumed, `dout_valid`=0, `overrun` remains 1.
- Assert `r` for one cycle after bit 3 of a frame, then send full 0xFE -> all outputs 0 after reset; next word `dout`=0x02, `dout_raw`=0xFE, `overrun`=0.
